// File: rtl/spi_ram_ctrl.sv
// SPI frame command sequencer and RAM arbiter.
// Shares one single-port RAM between SPI frames and a local host port.
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int TX_HOLD    = 8,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  spi_ovf
);

  localparam int CW = $clog2(TX_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE, SPI_ACC, SPI_RD, HOST_ACC, HOST_RD
  } state_t;

  state_t state, nxt;

  logic                  rx_valid_q;
  logic                  frame_evt;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [7:0]            pend_wdata;
  logic                  pend_we;
  logic                  spi_pend;
  logic                  prefer_host;
  logic [CW-1:0]         tx_cnt;
  logic                  spi_win;
  logic                  host_win;

  assign frame_evt = rx_valid & ~rx_valid_q;
  assign op        = rx_data[9:8];
  assign tx_valid  = (tx_cnt != '0);

  // pointer only matters when both sides contend
  assign spi_win  = spi_pend &
                    (~host_req | ~RR_EN | ~prefer_host);
  assign host_win = host_req & ~spi_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (spi_win)       nxt = SPI_ACC;
        else if (host_win) nxt = HOST_ACC;
        else               nxt = IDLE;
      end
      SPI_ACC:  nxt = pend_we ? IDLE : SPI_RD;
      SPI_RD:   nxt = IDLE;
      HOST_ACC: nxt = host_we ? IDLE : HOST_RD;
      HOST_RD:  nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    unique case (state)
      SPI_ACC: begin
        mem_en    = 1'b1;
        mem_we    = pend_we;
        mem_addr  = pend_addr;
        mem_wdata = pend_wdata;
      end
      HOST_ACC: begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        host_gnt  = 1'b1;
      end
      HOST_RD: begin
        host_rdata  = mem_rdata;
        host_rvalid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      pend_we     <= 1'b0;
      spi_pend    <= 1'b0;
      spi_ovf     <= 1'b0;
      prefer_host <= 1'b0;
      tx_data     <= '0;
      tx_cnt      <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      if (state == SPI_ACC) spi_pend <= 1'b0;
      if (frame_evt) begin
        unique case (op)
          2'b00: wr_addr <= rx_data[ADDR_WIDTH-1:0];
          2'b10: rd_addr <= rx_data[ADDR_WIDTH-1:0];
          default: begin
            if (spi_pend) begin
              spi_ovf <= 1'b1;
            end else begin
              spi_pend   <= 1'b1;
              pend_we    <= ~op[1];
              pend_addr  <= op[1] ? rd_addr : wr_addr;
              pend_wdata <= rx_data[7:0];
            end
          end
        endcase
      end
      if (state == IDLE && spi_pend && host_req)
        prefer_host <= spi_win;
      // a fresh capture restarts the hold window
      if (state == SPI_RD) begin
        tx_data <= mem_rdata;
        tx_cnt  <= CW'(TX_HOLD);
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed and random checks of spi_ram_ctrl against RAM and array models.
// Two instances: round-robin (dut) and fixed SPI priority (dut0).
module tb_spi_ram_ctrl;

  typedef struct {
    int         cyc;
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       host_req = 1'b0;
  logic       h0_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;

  logic [7:0] tx_data, host_rdata, mem_addr, mem_wdata;
  logic       tx_valid, host_gnt, host_rvalid;
  logic       mem_en, mem_we, spi_ovf;
  logic [7:0] mem_rdata = '0;

  logic [7:0] tx_data0, host_rdata0, mem_addr0, mem_wdata0;
  logic       tx_valid0, host_gnt0, host_rvalid0;
  logic       mem_en0, mem_we0, spi_ovf0;
  logic [7:0] mem_rdata0 = '0;

  logic [7:0] ram  [256] = '{default: 8'h00};
  logic [7:0] ram0 [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  acc_t q1[$];
  acc_t q0[$];
  int   txq[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .TX_HOLD(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .spi_ovf(spi_ovf)
  );

  spi_ram_ctrl #(.ADDR_WIDTH(8), .TX_HOLD(8), .RR_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data0), .tx_valid(tx_valid0),
    .host_req(h0_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt0), .host_rdata(host_rdata0),
    .host_rvalid(host_rvalid0),
    .mem_en(mem_en0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .spi_ovf(spi_ovf0)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
    if (mem_en0) begin
      if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
      else         mem_rdata0 <= ram0[mem_addr0];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en)
        q1.push_back('{cyc, host_gnt, mem_we, mem_addr, mem_wdata});
      if (mem_en0)
        q0.push_back('{cyc, host_gnt0, mem_we0, mem_addr0, mem_wdata0});
      if (tx_valid) txq.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t at1(input int i);
    acc_t z = '{-1, 1'b0, 1'b0, 8'h00, 8'h00};
    return (i < q1.size()) ? q1[i] : z;
  endfunction

  function automatic acc_t at0(input int i);
    acc_t z = '{-1, 1'b0, 1'b0, 8'h00, 8'h00};
    return (i < q0.size()) ? q0[i] : z;
  endfunction

  function automatic int tx_first();
    return (txq.size() > 0) ? txq[0] : -1;
  endfunction

  // waits on negedges; drops each host request once granted
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (host_gnt)  host_req = 1'b0;
      if (host_gnt0) h0_req = 1'b0;
    end
  endtask

  task automatic send(input logic [9:0] f, input int hold);
    rx_data  = f;
    rx_valid = 1'b1;
    idle(hold);
    rx_valid = 1'b0;
    idle(1);
  endtask

  task automatic host_op(input logic we,
                         input logic [7:0] a,
                         input logic [7:0] d);
    bit got = 1'b0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (host_gnt) got = 1'b1;
    end
    host_req = 1'b0;
    chk("host_gnt_seen", 32'(got), 32'd1);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      @(negedge clk);
      chk("host_rvalid", 32'(host_rvalid), 32'd1);
      chk("host_rdata", 32'(host_rdata), 32'(ref_mem[a]));
    end
    idle(2);
  endtask

  task automatic spi_read(input logic [7:0] a);
    bit got = 1'b0;
    send({2'b10, a}, 2);
    send(10'h300, 2);
    for (int i = 0; i < 10 && !got; i++) begin
      if (tx_valid) got = 1'b1;
      else idle(1);
    end
    chk("spi_rd_tx_seen", 32'(got), 32'd1);
    chk("spi_rd_data", 32'(tx_data), 32'(ref_mem[a]));
    idle(12);
  endtask

  initial begin
    int   c0;
    int   nspi;
    int   nhost;
    acc_t a;
    logic [7:0] ra, rd;

    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_spi_ovf", 32'(spi_ovf), 32'd0);
    chk("rst_host_gnt", 32'(host_gnt), 32'd0);

    // address load then write
    q1.delete();
    txq.delete();
    send(10'h0A5, 4);
    c0 = cyc;
    send(10'h13C, 4);
    idle(6);
    a = at1(0);
    chk("t1_count", 32'(q1.size()), 32'd1);
    chk("t1_cycle", 32'(a.cyc), 32'(c0 + 2));
    chk("t1_we", 32'(a.we), 32'd1);
    chk("t1_addr", 32'(a.addr), 32'hA5);
    chk("t1_data", 32'(a.data), 32'h3C);
    ref_mem[8'hA5] = 8'h3C;

    // read back with 8-cycle tx hold
    send(10'h2A5, 4);
    q1.delete();
    txq.delete();
    c0 = cyc;
    send(10'h300, 4);
    idle(12);
    a = at1(0);
    chk("t2_count", 32'(q1.size()), 32'd1);
    chk("t2_cycle", 32'(a.cyc), 32'(c0 + 2));
    chk("t2_we", 32'(a.we), 32'd0);
    chk("t2_addr", 32'(a.addr), 32'hA5);
    chk("t2_tx_start", 32'(tx_first()), 32'(c0 + 4));
    chk("t2_tx_len", 32'(txq.size()), 32'd8);
    chk("t2_tx_data", 32'(tx_data), 32'(ref_mem[8'hA5]));

    // long rx_valid level yields one event
    q1.delete();
    send(10'h155, 20);
    idle(4);
    a = at1(0);
    chk("t3_count", 32'(q1.size()), 32'd1);
    chk("t3_addr", 32'(a.addr), 32'hA5);
    chk("t3_data", 32'(a.data), 32'h55);
    chk("t3_ovf", 32'(spi_ovf), 32'd0);
    ref_mem[8'hA5] = 8'h55;

    // contention from reset: SPI first, then host
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    q1.delete();
    q0.delete();
    rx_data  = 10'h110;
    rx_valid = 1'b1;
    idle(1);
    host_req   = 1'b1;
    h0_req     = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h10;
    host_wdata = 8'h77;
    idle(1);
    rx_valid = 1'b0;
    idle(10);
    chk("t4a_count", 32'(q1.size()), 32'd2);
    chk("t4a_first_spi", 32'(at1(0).host), 32'd0);
    chk("t4a_first_data", 32'(at1(0).data), 32'h10);
    chk("t4a_second_host", 32'(at1(1).host), 32'd1);
    chk("t4a_second_addr", 32'(at1(1).addr), 32'h10);
    chk("t4a_fix_first_spi", 32'(at0(0).host), 32'd0);
    chk("t4a_fix_second_host", 32'(at0(1).host), 32'd1);
    ref_mem[8'h00] = 8'h10;
    ref_mem[8'h10] = 8'h77;

    // second contention: round-robin now favours host
    q1.delete();
    q0.delete();
    rx_data  = 10'h111;
    rx_valid = 1'b1;
    idle(1);
    host_req   = 1'b1;
    h0_req     = 1'b1;
    host_addr  = 8'h11;
    host_wdata = 8'h78;
    idle(1);
    rx_valid = 1'b0;
    idle(10);
    chk("t4b_first_host", 32'(at1(0).host), 32'd1);
    chk("t4b_second_spi", 32'(at1(1).host), 32'd0);
    chk("t4b_second_data", 32'(at1(1).data), 32'h11);
    chk("t4b_fix_first_spi", 32'(at0(0).host), 32'd0);
    chk("t4b_fix_second_host", 32'(at0(1).host), 32'd1);
    ref_mem[8'h00] = 8'h11;
    ref_mem[8'h11] = 8'h78;

    // second write frame while one is pending is dropped
    q1.delete();
    rx_data   = 10'h1AB;
    rx_valid  = 1'b1;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h10;
    idle(1);
    rx_valid = 1'b0;
    idle(1);
    chk("t5_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("t5_host_rdata", 32'(host_rdata), 32'(ref_mem[8'h10]));
    rx_data  = 10'h1CD;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
    idle(10);
    nspi  = 0;
    nhost = 0;
    foreach (q1[i]) begin
      if (q1[i].host) nhost++;
      else if (q1[i].we) begin
        nspi++;
        a = q1[i];
      end
    end
    chk("t5_spi_writes", 32'(nspi), 32'd1);
    chk("t5_host_accs", 32'(nhost), 32'd1);
    chk("t5_wr_data", 32'(a.data), 32'hAB);
    chk("t5_wr_addr", 32'(a.addr), 32'h00);
    chk("t5_ovf", 32'(spi_ovf), 32'd1);
    ref_mem[8'h00] = 8'hAB;

    // reset in the 4th cycle of a tx hold
    send(10'h210, 2);
    send(10'h300, 2);
    idle(4);
    chk("t6_tx_valid_pre", 32'(tx_valid), 32'd1);
    chk("t6_tx_data_pre", 32'(tx_data), 32'(ref_mem[8'h10]));
    rst_n = 1'b0;
    #1;
    chk("t6_tx_valid_rst", 32'(tx_valid), 32'd0);
    chk("t6_tx_data_rst", 32'(tx_data), 32'd0);
    chk("t6_mem_en_rst", 32'(mem_en), 32'd0);
    chk("t6_ovf_rst", 32'(spi_ovf), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    q1.delete();
    txq.delete();
    send(10'h300, 2);
    idle(12);
    a = at1(0);
    chk("t6_rd_count", 32'(q1.size()), 32'd1);
    chk("t6_rd_addr", 32'(a.addr), 32'h00);
    chk("t6_rd_we", 32'(a.we), 32'd0);
    chk("t6_tx_len", 32'(txq.size()), 32'd8);
    chk("t6_tx_data", 32'(tx_data), 32'(ref_mem[8'h00]));

    // random mix against the array model
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: begin
          send({2'b00, ra}, 2);
          send({2'b01, rd}, 2);
          ref_mem[ra] = rd;
          idle(4);
        end
        1: host_op(1'b1, ra, rd);
        2: spi_read(ra);
        default: host_op(1'b0, ra, 8'h00);
      endcase
    end
    chk("rnd_ovf", 32'(spi_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
